fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 146 ++++++++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word-aligned fetches, tracks up to two outstanding
// requests, buffers responses in a 2-entry FIFO and drops stale responses after a redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h1000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h7800_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] out_PC_next,
    output logic        instr_valid
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  inflight_q, inflight_d;
    logic [1:0]  discard_q, discard_d;
    logic [1:0]  occ_q, occ_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        req_q, req_d;

    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc4   [2];

    logic        grant;
    logic        rsp;
    logic        push;
    logic        pop;
    logic        head_valid;
    logic [31:0] rsp_pc4;
    logic [2:0]  pending_d;

    // Only the word address of a redirect target is meaningful.
    logic unused_redirect_pc_bits;
    assign unused_redirect_pc_bits = ^redirect_pc[1:0];

    // NOTE: every signal gets a default at the top of the block so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        grant      = req_q & imem_gnt;
        rsp        = imem_rvalid & (inflight_q != 2'd0);
        push       = rsp & (discard_q == 2'd0) & ~redirect;
        head_valid = (occ_q != 2'd0) & ~redirect;
        pop        = head_valid & ~stall;

        // Kept responses return in order, so the oldest outstanding address is PC
        // minus four bytes per request still in flight.
        rsp_pc4 = pc_q - {28'd0, inflight_q, 2'b00} + 32'd4;

        inflight_d = inflight_q + {1'b0, grant} - {1'b0, rsp};

        pc_d = pc_q;
        if (redirect) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (grant) begin
            pc_d = pc_q + 32'd4;
        end

        occ_d    = occ_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect) begin
            occ_d    = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
            rd_ptr_d = rd_ptr_q ^ pop;
            wr_ptr_d = wr_ptr_q ^ push;
        end

        // A redirect while already draining keeps the existing discard accounting.
        discard_d = discard_q;
        if (redirect && (state_q == RUN)) begin
            discard_d = inflight_d;
        end else if (rsp && (discard_q != 2'd0)) begin
            discard_d = discard_q - 2'd1;
        end

        state_d = state_q;
        case (state_q)
            RUN:     if (redirect && (inflight_d != 2'd0)) state_d = DRAIN;
            DRAIN:   if (inflight_d == 2'd0)               state_d = RUN;
            default: state_d = RUN;
        endcase

        // The request is registered from next-state values, so it only drops on a
        // grant or a flush and otherwise stays stable until accepted.
        pending_d = {1'b0, inflight_d} + {1'b0, occ_d};
        req_d     = (state_d == RUN) && (pending_d < 3'd2);
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge value of its inputs regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            inflight_q <= 2'd0;
            discard_q  <= 2'd0;
            occ_q      <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            req_q      <= req_d;
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; occupancy gates every read,
    // so stale contents are never visible and the array stays plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr_q] <= imem_rdata;
            fifo_pc4[wr_ptr_q]   <= rsp_pc4;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = {pc_q[31:2], 2'b00};
    assign instr_valid = head_valid;
    assign instr       = head_valid ? fifo_instr[rd_ptr_q] : NOP_INSTR;
    assign out_PC_next = head_valid ? fifo_pc4[rd_ptr_q] : 32'd0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table for the main flow,
// then hand sequences for wrap, redirect-in-drain and mid-transaction reset.
module tb_fetch_stage;

    localparam logic [31:0] B   = 32'h1000_0000;
    localparam logic [31:0] NOP = 32'h7800_0000;
    localparam logic [31:0] I0  = 32'h1111_1111;
    localparam logic [31:0] I1  = 32'h2222_2222;
    localparam logic [31:0] I2  = 32'h3333_3333;
    localparam logic [31:0] I3  = 32'h4444_4444;
    localparam logic [31:0] I4  = 32'h5555_5555;
    localparam logic [31:0] I5  = 32'h6666_0000;
    localparam logic [31:0] I6  = 32'h6666_6666;
    localparam logic [31:0] I7  = 32'h7777_7777;
    localparam int          NV  = 28;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] out_PC_next;
    logic        instr_valid;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_pcn;
    } vec_t;

    vec_t vecs [NV];

    fetch_stage #(
        .RESET_PC  (B),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .out_PC_next (out_PC_next),
        .instr_valid (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic gnt, input logic rv, input logic [31:0] rdata,
                                input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                                input logic [31:0] e_instr, input logic [31:0] e_pcn);
        vec_t v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
        v.e_instr = e_instr; v.e_pcn = e_pcn;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                              input logic e_vld, input logic [31:0] e_instr,
                              input logic [31:0] e_pcn);
        check({tag, " imem_req"},    {31'd0, imem_req},    {31'd0, e_req});
        check({tag, " imem_addr"},   imem_addr,            e_addr);
        check({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, e_vld});
        check({tag, " instr"},       instr,                e_instr);
        check({tag, " out_PC_next"}, out_PC_next,          e_pcn);
    endtask

    // Drive one cycle's inputs just after the falling edge, then let them settle.
    task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic gnt, input logic rv, input logic [31:0] rdata);
        @(negedge clk);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_gnt    = gnt;
        imem_rvalid = rv;
        imem_rdata  = rdata;
        #1;
    endtask

    initial begin
        //              st rd rpc      gnt rv rdata         req addr     vld instr pcn
        vecs[0]  = mk(0, 0, 0,        1, 0, 0,            0, B,        0, NOP, 0);
        vecs[1]  = mk(0, 0, 0,        1, 0, 0,            1, B,        0, NOP, 0);
        vecs[2]  = mk(0, 0, 0,        1, 1, I0,           1, B + 4,    0, NOP, 0);
        vecs[3]  = mk(0, 0, 0,        1, 1, I1,           0, B + 8,    1, I0,  B + 4);
        vecs[4]  = mk(1, 0, 0,        1, 0, 0,            1, B + 8,    1, I1,  B + 8);
        vecs[5]  = mk(1, 0, 0,        1, 1, I2,           0, B + 12,   1, I1,  B + 8);
        vecs[6]  = mk(1, 0, 0,        1, 0, 0,            0, B + 12,   1, I1,  B + 8);
        vecs[7]  = mk(1, 0, 0,        1, 0, 0,            0, B + 12,   1, I1,  B + 8);
        vecs[8]  = mk(1, 0, 0,        1, 0, 0,            0, B + 12,   1, I1,  B + 8);
        vecs[9]  = mk(0, 0, 0,        1, 0, 0,            0, B + 12,   1, I1,  B + 8);
        vecs[10] = mk(0, 0, 0,        0, 0, 0,            1, B + 12,   1, I2,  B + 12);
        vecs[11] = mk(0, 0, 0,        0, 0, 0,            1, B + 12,   0, NOP, 0);
        vecs[12] = mk(0, 0, 0,        0, 0, 0,            1, B + 12,   0, NOP, 0);
        vecs[13] = mk(0, 0, 0,        0, 0, 0,            1, B + 12,   0, NOP, 0);
        vecs[14] = mk(0, 0, 0,        0, 0, 0,            1, B + 12,   0, NOP, 0);
        vecs[15] = mk(0, 0, 0,        1, 0, 0,            1, B + 12,   0, NOP, 0);
        vecs[16] = mk(0, 0, 0,        1, 1, I3,           1, B + 16,   0, NOP, 0);
        vecs[17] = mk(0, 0, 0,        1, 0, 0,            0, B + 20,   1, I3,  B + 16);
        vecs[18] = mk(0, 0, 0,        1, 0, 0,            1, B + 20,   0, NOP, 0);
        vecs[19] = mk(0, 1, B + 'h42, 1, 0, 0,            0, B + 24,   0, NOP, 0);
        vecs[20] = mk(0, 0, 0,        1, 1, I4,           0, B + 'h40, 0, NOP, 0);
        vecs[21] = mk(0, 0, 0,        1, 1, I5,           0, B + 'h40, 0, NOP, 0);
        vecs[22] = mk(0, 0, 0,        1, 0, 0,            1, B + 'h40, 0, NOP, 0);
        vecs[23] = mk(0, 0, 0,        1, 1, I6,           1, B + 'h44, 0, NOP, 0);
        vecs[24] = mk(0, 0, 0,        0, 1, I7,           0, B + 'h48, 1, I6,  B + 'h44);
        vecs[25] = mk(1, 0, 0,        0, 1, 32'h9999_9999, 1, B + 'h48, 1, I7,  B + 'h48);
        vecs[26] = mk(0, 0, 0,        0, 0, 0,            1, B + 'h48, 1, I7,  B + 'h48);
        vecs[27] = mk(0, 0, 0,        0, 0, 0,            1, B + 'h48, 0, NOP, 0);

        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, B, 1'b0, NOP, 32'd0);

        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
            check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld,
                       vecs[i].e_instr, vecs[i].e_pcn);
        end

        // Redirect to an unaligned top-of-memory address, then wrap through zero.
        cyc(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        check_outs("wrap redirect", 1'b1, B + 'h48, 1'b0, NOP, 32'd0);
        cyc(0, 0, 0, 1, 0, 0);
        check_outs("wrap issue", 1'b1, 32'hFFFF_FFFC, 1'b0, NOP, 32'd0);
        cyc(0, 0, 0, 0, 1, 32'h8888_8888);
        check_outs("wrap next", 1'b1, 32'h0000_0000, 1'b0, NOP, 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        check_outs("wrap head", 1'b1, 32'h0000_0000, 1'b1, 32'h8888_8888, 32'h0000_0000);
        redirect    = 1'b1;
        redirect_pc = B + 'h100;
        #1;
        check_outs("redirect masks head", 1'b1, 32'h0000_0000, 1'b0, NOP, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        check_outs("redirect idle", 1'b1, B + 'h100, 1'b0, NOP, 32'd0);

        // Second redirect while draining: PC moves again, discards are not doubled.
        cyc(0, 0, 0, 1, 0, 0);
        check_outs("drain a", 1'b1, B + 'h100, 1'b0, NOP, 32'd0);
        cyc(0, 1, B + 'h200, 1, 0, 0);
        check_outs("drain b", 1'b1, B + 'h104, 1'b0, NOP, 32'd0);
        cyc(0, 1, B + 'h300, 1, 1, 32'hCCCC_CCCC);
        check_outs("drain c", 1'b0, B + 'h200, 1'b0, NOP, 32'd0);
        cyc(0, 0, 0, 1, 1, 32'hDDDD_DDDD);
        check_outs("drain d", 1'b0, B + 'h300, 1'b0, NOP, 32'd0);
        cyc(0, 0, 0, 1, 0, 0);
        check_outs("drain e", 1'b1, B + 'h300, 1'b0, NOP, 32'd0);
        cyc(0, 0, 0, 0, 1, 32'hAAAA_AAAA);
        check_outs("drain f", 1'b1, B + 'h304, 1'b0, NOP, 32'd0);
        cyc(0, 0, 0, 1, 0, 0);
        check_outs("drain g", 1'b1, B + 'h304, 1'b1, 32'hAAAA_AAAA, B + 'h304);

        // Reset with one request outstanding, then a stray response after release.
        cyc(0, 0, 0, 0, 0, 0);
        check_outs("pre reset", 1'b1, B + 'h308, 1'b0, NOP, 32'd0);
        rst_n = 1'b0;
        #1;
        check_outs("async reset", 1'b0, B, 1'b0, NOP, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBBBB_BBBB;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("release", 1'b0, B, 1'b0, NOP, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        check_outs("post reset a", 1'b1, B, 1'b0, NOP, 32'd0);
        cyc(0, 0, 0, 1, 0, 0);
        check_outs("post reset b", 1'b1, B, 1'b0, NOP, 32'd0);
        cyc(0, 0, 0, 0, 1, 32'hEEEE_EEEE);
        check_outs("post reset c", 1'b1, B + 4, 1'b0, NOP, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        check_outs("post reset d", 1'b1, B + 4, 1'b1, 32'hEEEE_EEEE, B + 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
